// File: rtl/cache_ctrl.sv
// Direct-mapped read-allocate write-through cache between the CPU port and bus_unit.
// Load hits complete 2 cycles after cpu_req; misses, stores and uncached loads stall until the bus answers.
module cache_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int BUS_ADDR   = 24,
  parameter int LINE_BYTES = 128,
  parameter int LINES      = 4,
  localparam int OFF       = $clog2(LINE_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic                 cpu_uncached,
  input  logic [BUS_ADDR-1:0]  cpu_addr,
  input  logic [BUS_WIDTH-1:0] cpu_wdata,
  output logic [BUS_WIDTH-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic                 read_line_req,
  output logic                 read_req,
  output logic                 write_through_req,
  output logic [BUS_ADDR-1:0]  pa,
  output logic [BUS_WIDTH-1:0] wt_data,
  input  logic [BUS_WIDTH-1:0] line_data,
  input  logic [OFF-1:0]       addr_count,
  input  logic                 line_write,
  input  logic                 trans_rdy,
  input  logic                 bus_error
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG   = BUS_ADDR - IDX - OFF;
  localparam int DEPTH = LINES * LINE_BYTES;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, SRD, WT} state_t;

  state_t               state_q;
  logic [BUS_ADDR-1:0]  addr_q;
  logic                 we_q;
  logic                 unc_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [LINES-1:0]     valid_q;
  logic [TAG-1:0]       tags_q [LINES];
  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] rd_q;
  logic [BUS_WIDTH-1:0] cpu_rdata_q;
  logic                 cpu_ready_q;
  logic                 cpu_err_q;
  logic [BUS_ADDR-1:0]  pa_q;
  logic [BUS_WIDTH-1:0] wt_data_q;

  logic [OFF-1:0]       a_off;
  logic [IDX-1:0]       a_idx;
  logic [TAG-1:0]       a_tag;
  logic                 hit;
  logic                 accept;
  logic                 refill_done;
  logic                 mem_we;
  logic [IDX+OFF-1:0]   mem_waddr;
  logic [BUS_WIDTH-1:0] mem_wdat;
  logic                 rd_en;
  logic [IDX+OFF-1:0]   rd_addr;
  logic                 rd_byp;

  assign a_off       = addr_q[OFF-1:0];
  assign a_idx       = addr_q[OFF+IDX-1:OFF];
  assign a_tag       = addr_q[BUS_ADDR-1:OFF+IDX];
  assign hit         = valid_q[a_idx] && (tags_q[a_idx] == a_tag);
  assign accept      = (state_q == IDLE) && !flush && cpu_req;
  assign refill_done = (state_q == REFILL) && trans_rdy && !bus_error;

  assign read_line_req     = (state_q == REFILL);
  assign read_req          = (state_q == SRD);
  assign write_through_req = (state_q == WT);
  assign cpu_rdata         = cpu_rdata_q;
  assign cpu_ready         = cpu_ready_q;
  assign cpu_err           = cpu_err_q;
  assign pa                = pa_q;
  assign wt_data           = wt_data_q;

  // A store that hits updates the line even when marked uncached, so the cache never holds stale data.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {a_idx, a_off};
    mem_wdat  = wdata_q;
    if (state_q == REFILL && line_write) begin
      mem_we    = 1'b1;
      mem_waddr = {a_idx, addr_count};
      mem_wdat  = line_data;
    end else if (state_q == LOOKUP && we_q && hit) begin
      mem_we = 1'b1;
    end
    rd_en   = accept || refill_done;
    rd_addr = accept ? cpu_addr[OFF+IDX-1:0] : {a_idx, a_off};
    // The last refill beat lands in the same cycle as the re-read.
    rd_byp  = refill_done && line_write && (addr_count == a_off);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdat;
    if (rd_en) rd_q <= rd_byp ? line_data : mem_q[rd_addr];
    if (refill_done) tags_q[a_idx] <= a_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      unc_q       <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      pa_q        <= '0;
      wt_data_q   <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            unc_q   <= cpu_uncached;
            wdata_q <= cpu_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (we_q) begin
            pa_q      <= addr_q;
            wt_data_q <= wdata_q;
            state_q   <= WT;
          end else if (unc_q) begin
            pa_q    <= addr_q;
            state_q <= SRD;
          end else if (hit) begin
            cpu_rdata_q <= rd_q;
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            pa_q           <= {a_tag, a_idx, {OFF{1'b0}}};
            valid_q[a_idx] <= 1'b0;
            state_q        <= REFILL;
          end
        end
        REFILL: begin
          if (bus_error) begin
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else if (trans_rdy) begin
            valid_q[a_idx] <= 1'b1;
            state_q        <= LOOKUP;
          end
        end
        SRD: begin
          if (bus_error) begin
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else if (trans_rdy) begin
            cpu_rdata_q <= line_data;
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        WT: begin
          if (bus_error || trans_rdy) begin
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= bus_error;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a negedge bus responder that counts requests.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, cpu_req, cpu_we, cpu_uncached;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic        read_line_req, read_req, write_through_req;
  logic [23:0] pa;
  logic [7:0]  wt_data, line_data;
  logic [6:0]  addr_count;
  logic        line_write, trans_rdy, bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  int          beat = 0;
  int          err_beat = -1;
  logic [7:0]  srd_data = 8'h00;
  int          n_line = 0, n_rd = 0, n_wt = 0;
  logic [23:0] last_pa = '0;
  logic [7:0]  last_wt = '0;
  logic        prev_line = 1'b0, prev_rd = 1'b0, prev_wt = 1'b0;

  logic [7:0]  got_rdata;
  logic        got_err;
  int          cyc;
  int          l0, r0, w0;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_uncached(cpu_uncached), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .read_line_req(read_line_req), .read_req(read_req),
    .write_through_req(write_through_req), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .trans_rdy(trans_rdy), .bus_error(bus_error)
  );

  initial forever #5 clk = ~clk;

  // Bus responder: refill beats carry offset^0x5A; single reads/writes complete at once.
  initial begin
    line_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
    line_data = '0; addr_count = '0;
    forever begin
      @(negedge clk);
      line_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
      if (read_line_req) begin
        if (!prev_line) begin n_line++; last_pa = pa; beat = 0; end
        if (beat == err_beat) begin
          bus_error = 1'b1;
        end else begin
          line_write = 1'b1;
          addr_count = beat[6:0];
          line_data  = beat[7:0] ^ 8'h5A;
          if (beat == 127) trans_rdy = 1'b1;
        end
        beat++;
      end
      if (read_req) begin
        if (!prev_rd) begin n_rd++; last_pa = pa; end
        line_data = srd_data;
        trans_rdy = 1'b1;
      end
      if (write_through_req) begin
        if (!prev_wt) begin n_wt++; last_pa = pa; last_wt = wt_data; end
        trans_rdy = 1'b1;
      end
      prev_line = read_line_req; prev_rd = read_req; prev_wt = write_through_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic unc, input logic [23:0] addr,
                        input logic [7:0] wd, output int cycles);
    logic found;
    found = 1'b0;
    cycles = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_uncached = unc; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      cycles++;
      if (cpu_ready) begin
        found = 1'b1;
        got_rdata = cpu_rdata;
        got_err = cpu_err;
      end
    end
    cpu_req = 1'b0;
    check("ready_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic hit10;
    rst = 1'b1; flush = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_uncached = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_err", {31'd0, cpu_err}, 32'd0);
    check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rst_reqs", {29'd0, read_line_req, read_req, write_through_req}, 32'd0);
    check("rst_pa", {8'd0, pa}, 32'd0);
    check("rst_wt", {24'd0, wt_data}, 32'd0);

    // Cold miss and refill, then a hit in the same line.
    access(1'b0, 1'b0, 24'h001280, 8'h00, cyc);
    check("fill_nline", n_line, 1);
    check("fill_pa", {8'd0, last_pa}, 32'h001280);
    check("fill_rdata", {24'd0, got_rdata}, 32'h5A);
    check("fill_err", {31'd0, got_err}, 32'd0);
    l0 = n_line; r0 = n_rd; w0 = n_wt;
    access(1'b0, 1'b0, 24'h0012A3, 8'h00, cyc);
    check("hit_lat", cyc, 2);
    check("hit_rdata", {24'd0, got_rdata}, 32'h79);
    check("hit_nobus", n_line + n_rd + n_wt, l0 + r0 + w0);

    // Store hit: write-through carries address/data, reload sees new byte.
    access(1'b1, 1'b0, 24'h0012A3, 8'hC4, cyc);
    check("st_nwt", n_wt, w0 + 1);
    check("st_pa", {8'd0, last_pa}, 32'h0012A3);
    check("st_wtdata", {24'd0, last_wt}, 32'hC4);
    access(1'b0, 1'b0, 24'h0012A3, 8'h00, cyc);
    check("st_reload", {24'd0, got_rdata}, 32'hC4);
    check("st_reload_lat", cyc, 2);
    check("st_reload_nline", n_line, l0);

    // Store miss does not allocate.
    access(1'b1, 1'b0, 24'h003000, 8'h11, cyc);
    check("stm_nwt", n_wt, w0 + 2);
    check("stm_nline", n_line, l0);
    access(1'b0, 1'b0, 24'h003000, 8'h00, cyc);
    check("stm_ld_nline", n_line, l0 + 1);
    check("stm_ld_pa", {8'd0, last_pa}, 32'h003000);
    check("stm_ld_rdata", {24'd0, got_rdata}, 32'h5A);

    // Uncached loads always go to the bus.
    srd_data = 8'h3E;
    r0 = n_rd;
    access(1'b0, 1'b1, 24'h7FFF01, 8'h00, cyc);
    check("unc_nrd", n_rd, r0 + 1);
    check("unc_pa", {8'd0, last_pa}, 32'h7FFF01);
    check("unc_rdata", {24'd0, got_rdata}, 32'h3E);
    access(1'b0, 1'b1, 24'h7FFF01, 8'h00, cyc);
    check("unc_rep_nrd", n_rd, r0 + 2);

    // Bus error at beat 40 of a refill.
    err_beat = 40;
    l0 = n_line;
    access(1'b0, 1'b0, 24'h004105, 8'h00, cyc);
    check("err_flag", {31'd0, got_err}, 32'd1);
    check("err_rdata_kept", {24'd0, got_rdata}, 32'h3E);
    tick();
    check("err_pulse", {30'd0, cpu_ready, cpu_err}, 32'd0);
    err_beat = -1;
    access(1'b0, 1'b0, 24'h004105, 8'h00, cyc);
    check("err_refill", n_line, l0 + 2);
    check("err_refill_pa", {8'd0, last_pa}, 32'h004100);
    check("err_refill_rdata", {24'd0, got_rdata}, 32'h5F);
    check("err_refill_err", {31'd0, got_err}, 32'd0);

    // Flush invalidates every line.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    l0 = n_line;
    access(1'b0, 1'b0, 24'h004105, 8'h00, cyc);
    check("flush_miss2", n_line, l0 + 1);
    access(1'b0, 1'b0, 24'h0012A3, 8'h00, cyc);
    check("flush_miss1", n_line, l0 + 2);
    check("flush_rdata", {24'd0, got_rdata}, 32'h79);

    // Reset in the middle of a refill.
    l0 = n_line;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_uncached = 1'b0; cpu_addr = 24'h003000;
    hit10 = 1'b0;
    for (int i = 0; i < 400 && !hit10; i++) begin
      tick();
      if (read_line_req && beat == 10) hit10 = 1'b1;
    end
    check("rst_mid_reach", {31'd0, hit10}, 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rstm_reqs", {29'd0, read_line_req, read_req, write_through_req}, 32'd0);
    check("rstm_ready", {30'd0, cpu_ready, cpu_err}, 32'd0);
    check("rstm_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rstm_pa", {8'd0, pa}, 32'd0);
    tick();
    access(1'b0, 1'b0, 24'h0012A3, 8'h00, cyc);
    check("rstm_miss", n_line, l0 + 2);
    check("rstm_rdata2", {24'd0, got_rdata}, 32'h79);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped, read-allocate, write-through, no-write-allocate cache controller with internal tag/valid/data storage.
Sits between the CPU load/store port and bus_unit. It drives bus_unit's read_line_req, read_req and write_through_req, and consumes its line_data, addr_count, line_write, trans_rdy and bus_error.
Serves hits locally and stalls the CPU through cpu_ready on misses, write-throughs and uncached reads.

Parameters:
BUS_WIDTH, 8, data width on CPU and bus side
BUS_ADDR, 24, physical address width
LINE_BYTES, 128, bytes per line; must equal bus_unit MAX_BURST; OFF=clog2(LINE_BYTES)
LINES, 4, number of lines; IDX=clog2(LINES); TAG=BUS_ADDR-IDX-OFF

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  invalidate all lines (1-cycle pulse)
cpu_req  in  1  access request, held until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_uncached  in  1  bypass cache for this access
cpu_addr  in  BUS_ADDR  byte address
cpu_wdata  in  BUS_WIDTH  store data
cpu_rdata  out  BUS_WIDTH  load data, valid when cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  bus fault, pulses together with cpu_ready
read_line_req  out  1  line refill request to bus_unit
read_req  out  1  single read request
write_through_req  out  1  single write request
pa  out  BUS_ADDR  bus address; line-aligned during refill
wt_data  out  BUS_WIDTH  write-through data
line_data  in  BUS_WIDTH  refill/single read data
addr_count  in  OFF  line offset of the current line_data
line_write  in  1  line_data valid for refill write
trans_rdy  in  1  bus transfer complete
bus_error  in  1  bus access fault

Behaviour:
- Reset: state IDLE; all valid bits 0; cpu_ready=0, cpu_err=0, cpu_rdata=0; all three requests 0; pa=0, wt_data=0. Tag and data contents are don't-care.
- Requests are decoded from the state register only; there is no combinational path from bus inputs to requests. pa and wt_data are registered at acceptance.
- Address split: offset=cpu_addr[OFF-1:0], index=[OFF+IDX-1:OFF], tag=upper TAG bits.
- States: IDLE, LOOKUP, REFILL, SRD, WT.
- IDLE:
  - flush has priority: clear all valid bits this cycle and ignore cpu_req for that cycle.
  - Otherwise on cpu_req: latch addr, we, uncached and wdata; issue synchronous data-array read; go to LOOKUP.
- LOOKUP (hit = valid[idx] & tag match):
  - Load, cached, hit: cpu_rdata <= array byte; cpu_ready=1; go to IDLE. Load-hit latency is 2 cycles from cpu_req to cpu_ready.
  - Load, cached, miss: go to REFILL; pa = {tag, idx, OFF'b0}.
  - Load, uncached: go to SRD; pa = addr.
  - Store: if cached hit, update array byte now; go to WT; pa = addr; wt_data = wdata. A store miss or an uncached store does not allocate.
- REFILL:
  - read_line_req=1. Each line_write writes line_data to array[idx][addr_count].
  - Clear valid[idx] on entry.
  - On trans_rdy: set valid[idx], write tag; go to LOOKUP, which re-reads and hits. The last beat has line_write and trans_rdy together, and both are honoured.
- SRD: read_req=1. On trans_rdy: cpu_rdata <= line_data; cpu_ready=1; go to IDLE. The cache is untouched.
- WT: write_through_req=1. On trans_rdy: cpu_ready=1; go to IDLE.
- bus_error in REFILL, SRD or WT:
  - cpu_ready=1, cpu_err=1 for one cycle; go to IDLE.
  - In REFILL, valid[idx] stays 0.
  - cpu_rdata is unchanged on error.
- The request deasserts in the cycle after trans_rdy or bus_error, so bus_unit (back in stb) sees no request. cpu_req must be dropped or changed after cpu_ready; if still high in IDLE it is a new access.
- flush outside IDLE is ignored.
- rst mid-operation (any state): next cycle is IDLE with outputs at reset values and all lines invalid. A partial refill is discarded.

Test Plan:
- Load 0x001280 on an empty cache -> read_line_req with pa=0x001280; 128 line_write beats with data=offset^0x5A; cpu_ready with cpu_rdata=0x5A. Then load 0x0012A3 -> cpu_ready 2 cycles after cpu_req, rdata=0x79, no bus request.
- Store 0x0012A3 data 0xC4 on a hit -> write_through_req with pa=0x0012A3, wt_data=0xC4; after trans_rdy a reload returns 0xC4 with no bus traffic.
- Store to a miss at 0x003000, then load 0x003000 -> write_through_req first; the load then raises read_line_req, proving no allocation on the store.
- Uncached load 0x7FFF01 with bus data 0x3E -> read_req with pa=0x7FFF01; cpu_rdata=0x3E; a repeat issues read_req again.
- bus_error at beat 40 of a refill -> cpu_ready=cpu_err=1 for one cycle; reloading the same line issues read_line_req again.
- flush pulse after line fill, and rst asserted at beat 10 of a refill -> all subsequent loads miss; requests are 0 the cycle after rst.
